// File: rtl/reg_bank_pkg.sv
// Shared definitions for the reg_bank_n register bank: operation encoding.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_cell.sv
// One WIDTH-bit register of the bank: applies load/inc/dec/clear when selected
// and reports whether the applied operation wraps around.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_we,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_next = r_q;
    o_wrap = 1'b0;
    if (i_we) begin
      case (i_op)
        OP_LOAD: w_next = i_d;
        OP_INC: begin
          w_next = r_q + 1'b1;
          o_wrap = &r_q;
        end
        OP_DEC: begin
          w_next = r_q - 1'b1;
          o_wrap = ~|r_q;
        end
        OP_CLR:  w_next = '0;
        default: w_next = r_q;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all cells update together
  // from pre-edge values. Every register is reset: the bank must read 0
  // during reset, so it cannot be treated as an unreset memory array.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_q <= '0;
    else        r_q <= w_next;
  end

  assign o_q = r_q;

endmodule : reg_bank_cell

// File: rtl/reg_bank_n.sv
// DEPTH-entry register bank with one op-write port, two combinational read
// ports and a registered wrap flag. Define REG_BANK_BYPASS_EN to forward loads.
module reg_bank_n
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [1:0]       OP,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    RA,
  input  logic [AW-1:0]    RB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             WRAP
);

  op_e              w_op;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_cell_wrap;
  logic [WIDTH-1:0] w_q [DEPTH];
  logic             w_fwd;
  logic             r_wrap;

  assign w_op = op_e'(OP);

  // An out-of-range WA matches no cell, so the write is silently dropped.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    assign w_sel[g] = (WA == AW'(g));

    reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .i_we   (!EN && w_sel[g]),
      .i_op   (w_op),
      .i_d    (D),
      .o_q    (w_q[g]),
      .o_wrap (w_cell_wrap[g])
    );
  end

`ifdef REG_BANK_BYPASS_EN
  // A load discarded by reset is not forwarded either.
  assign w_fwd = RST_N && !EN && (w_op == OP_LOAD);
`else
  assign w_fwd = 1'b0;
`endif

  always_comb begin
    QA = '0;
    QB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RA == AW'(i)) QA = (w_fwd && w_sel[i]) ? D : w_q[i];
      if (RB == AW'(i)) QB = (w_fwd && w_sel[i]) ? D : w_q[i];
    end
  end

  // At most one cell is selected, so the OR is that cell's wrap (or 0).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_wrap <= 1'b0;
    else        r_wrap <= |w_cell_wrap;
  end

  assign WRAP = r_wrap;

endmodule : reg_bank_n

// File: tb/tb_reg_bank_n.sv
// Self-checking bench for reg_bank_n: directed scenarios plus random traffic
// against an array model, on a DEPTH=4 and a DEPTH=3 instance in parallel.
module tb_reg_bank_n;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [1:0] OP;
  logic [1:0] WA;
  logic [7:0] D;
  logic [1:0] RA;
  logic [1:0] RB;
  logic [7:0] qa4, qb4, qa3, qb3;
  logic       wrap4, wrap3;

  int errors = 0;
  int checks = 0;

  int mdl [2][4];
  int dep [2] = '{4, 3};
  bit exp_wrap [2];

  reg_bank_n #(.WIDTH(8), .DEPTH(4), .AW(2)) u_dut4 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .OP(OP), .WA(WA), .D(D),
    .RA(RA), .RB(RB), .QA(qa4), .QB(qb4), .WRAP(wrap4)
  );

  reg_bank_n #(.WIDTH(8), .DEPTH(3), .AW(2)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .OP(OP), .WA(WA), .D(D),
    .RA(RA), .RB(RB), .QA(qa3), .QB(qb3), .WRAP(wrap3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Register contents as seen by a reader, including load forwarding.
  function automatic int exp_read(input int k, input logic [1:0] addr);
    if (int'(addr) >= dep[k]) return 0;
    if (BYPASS && RST_N && !EN && OP == 2'b00 && WA == addr) return int'(D);
    return mdl[k][addr];
  endfunction

  function automatic void model_edge();
    int v;
    for (int k = 0; k < 2; k++) begin
      exp_wrap[k] = 1'b0;
      if (!EN && int'(WA) < dep[k]) begin
        v = mdl[k][WA];
        case (OP)
          2'b00: v = int'(D);
          2'b01: begin exp_wrap[k] = (v == 255); v = (v + 1) % 256;   end
          2'b10: begin exp_wrap[k] = (v == 0);   v = (v + 255) % 256; end
          default: v = 0;
        endcase
        mdl[k][WA] = v;
      end
    end
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_wrap[k] = 1'b0;
      for (int i = 0; i < 4; i++) mdl[k][i] = 0;
    end
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_qa4"}, qa4, exp_read(0, RA));
    check({tag, "_qb4"}, qb4, exp_read(0, RB));
    check({tag, "_qa3"}, qa3, exp_read(1, RA));
    check({tag, "_qb3"}, qb3, exp_read(1, RB));
  endtask

  // Called at posedge+1: drive, check reads mid-cycle, clock, check results.
  task automatic cycle(input logic en_i, input logic [1:0] op_i, input logic [1:0] wa_i,
                       input logic [7:0] d_i, input logic [1:0] ra_i, input logic [1:0] rb_i);
    EN = en_i; OP = op_i; WA = wa_i; D = d_i; RA = ra_i; RB = rb_i;
    #3;
    check_reads("pre");
    @(posedge CLK);
    model_edge();
    #1;
    check("wrap4", wrap4, exp_wrap[0]);
    check("wrap3", wrap3, exp_wrap[1]);
    check_reads("post");
  endtask

  initial begin
    model_reset();
    RST_N = 1'b0; EN = 1'b1; OP = 2'b00; WA = '0; D = '0; RA = 2'd0; RB = 2'd1;
    #12;
    check("rst_qa4", qa4, 0);
    check("rst_qb4", qb4, 0);
    check("rst_wrap4", wrap4, 0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Load then read two ports.
    cycle(1'b0, 2'b00, 2'd2, 8'hA5, 2'd2, 2'd1);
    cycle(1'b1, 2'b00, 2'd0, 8'h00, 2'd2, 2'd1);
    check("load_qa", qa4, 8'hA5);
    check("load_qb", qb4, 8'h00);

    // Increment wrap, flag for one cycle only.
    cycle(1'b0, 2'b00, 2'd1, 8'hFF, 2'd1, 2'd1);
    cycle(1'b0, 2'b01, 2'd1, 8'h00, 2'd1, 2'd1);
    check("inc_wrap", wrap4, 1'b1);
    check("inc_val", qa4, 8'h00);
    cycle(1'b1, 2'b00, 2'd1, 8'h00, 2'd1, 2'd1);
    check("inc_wrap_gone", wrap4, 1'b0);

    // Decrement wrap on reg3 (out of range for the DEPTH=3 instance).
    cycle(1'b0, 2'b11, 2'd3, 8'h00, 2'd3, 2'd3);
    cycle(1'b0, 2'b10, 2'd3, 8'h00, 2'd3, 2'd3);
    check("dec_val", qa4, 8'hFF);
    check("dec_wrap", wrap4, 1'b1);
    check("dec_wrap3_oor", wrap3, 1'b0);
    cycle(1'b1, 2'b10, 2'd3, 8'h00, 2'd3, 2'd3);
    check("dec_wrap_gone", wrap4, 1'b0);

    // Hold with EN=1 and OP=clear.
    cycle(1'b1, 2'b11, 2'd2, 8'h00, 2'd2, 2'd3);
    check("hold_qa", qa4, 8'hA5);
    check("hold_qb", qb4, 8'hFF);

    // Out-of-range write on DEPTH=3 instance.
    cycle(1'b0, 2'b00, 2'd3, 8'h77, 2'd3, 2'd3);
    check("oor_qa3", qa3, 8'h00);
    check("oor_wrap3", wrap3, 1'b0);

    // Load forwarding onto read port A.
    cycle(1'b0, 2'b00, 2'd0, 8'h11, 2'd0, 2'd0);
    EN = 1'b0; OP = 2'b00; WA = 2'd0; D = 8'h3C; RA = 2'd0; RB = 2'd2;
    #1;
    check("bypass_qa", qa4, BYPASS ? 8'h3C : 8'h11);
    check("bypass_qb", qb4, 8'hA5);
    cycle(1'b0, 2'b00, 2'd0, 8'h3C, 2'd0, 2'd2);
    check("bypass_after", qa4, 8'h3C);

    // Reset asserted mid-cycle with WRAP high and a load pending.
    cycle(1'b0, 2'b00, 2'd1, 8'hFF, 2'd1, 2'd1);
    cycle(1'b0, 2'b01, 2'd1, 8'h00, 2'd1, 2'd1);
    EN = 1'b0; OP = 2'b00; WA = 2'd2; D = 8'h99; RA = 2'd2; RB = 2'd0;
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    check("midrst_qa", qa4, 8'h00);
    check("midrst_qb", qb4, 8'h00);
    check("midrst_wrap", wrap4, 1'b0);
    @(posedge CLK); #1;
    check("rst_discard_qa", qa4, 8'h00);
    check("rst_discard_qa3", qa3, 8'h00);
    RST_N = 1'b1;
    cycle(1'b0, 2'b00, 2'd2, 8'h99, 2'd2, 2'd0);
    check("first_op_after_rst", qa4, 8'h99);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic       en_r;
      logic [1:0] op_r, wa_r, ra_r, rb_r;
      logic [7:0] d_r;
      en_r = ($urandom_range(0, 3) == 0);
      op_r = 2'($urandom_range(0, 3));
      wa_r = 2'($urandom_range(0, 3));
      d_r  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        ra_r = wa_r;
        rb_r = wa_r;
      end else begin
        ra_r = 2'($urandom_range(0, 3));
        rb_r = 2'($urandom_range(0, 3));
      end
      cycle(en_r, op_r, wa_r, d_r, ra_r, rb_r);
      if (ra_r == rb_r) check("same_addr", qa4, qb4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_bank_n

// File: doc/reg_bank_n.md
REG_BANK_N -- requirements
Module: reg_bank_n

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each register.
REQ-002 Parameter DEPTH, default 4: number of registers, range 2..16.
REQ-003 Parameter AW, default 2: address width; SHALL satisfy 2**AW >= DEPTH.
REQ-004 Port CLK, input, 1: single clock; all state SHALL update on the rising edge.
REQ-005 Port RST_N, input, 1: reset, asynchronous, active-low.
REQ-006 Port EN, input, 1: write-cycle enable, active-low.
REQ-007 Port OP, input, 2: operation select: 00 load, 01 increment, 10 decrement, 11 clear.
REQ-008 Port WA, input, AW: target register address.
REQ-009 Port D, input, WIDTH: load data.
REQ-010 Port RA, input, AW: read address for port A.
REQ-011 Port RB, input, AW: read address for port B.
REQ-012 Port QA, output, WIDTH: contents of register RA.
REQ-013 Port QB, output, WIDTH: contents of register RB.
REQ-014 Port WRAP, output, 1: registered wrap flag for the most recent operation.

Function
REQ-015 When EN=1 at a rising edge, the block SHALL hold all registers and SHALL drive WRAP=0 on the following cycle.
REQ-016 When EN=0 and WA<DEPTH, exactly register WA SHALL change, per OP; all other registers SHALL hold.
REQ-017 Load (OP=00): reg[WA] <= D.
REQ-018 Increment (OP=01): reg[WA] <= reg[WA]+1 modulo 2**WIDTH.
REQ-019 Decrement (OP=10): reg[WA] <= reg[WA]-1 modulo 2**WIDTH.
REQ-020 Clear (OP=11): reg[WA] <= 0.
REQ-021 WRAP SHALL be 1 for exactly the cycle following an edge where:
- an increment took all-ones to 0, or
- a decrement took 0 to all-ones.
WRAP SHALL be 0 after every other edge.
REQ-022 When EN=0 and WA>=DEPTH, the write SHALL be ignored: no register changes and WRAP=0.
REQ-023 QA and QB SHALL be combinational reads of the current register contents, with zero-cycle latency.
REQ-024 A read address >= DEPTH SHALL return 0.
REQ-025 RA=RB=WA simultaneously SHALL be legal; both ports SHALL return an identical value.

Reset
REQ-026 While RST_N=0, all registers SHALL be 0 and WRAP SHALL be 0, regardless of CLK.
REQ-027 A reset asserted in the middle of a cycle SHALL discard any pending operation.
REQ-028 After RST_N deasserts, the first operation SHALL take effect on the first rising edge at which RST_N=1 and EN=0.

Configuration
REQ-029 Macro REG_BANK_BYPASS_EN SHALL control write-through forwarding.
- Defined: when EN=0, OP=00 and RA (or RB) equals WA<DEPTH, QA (or QB) SHALL show D combinationally in the same cycle.
- Undefined: reads SHALL show the pre-edge stored value, with no forwarding.
- Increment, decrement and clear SHALL never be forwarded in either configuration.

Structure
REQ-030 Package reg_bank_pkg SHALL hold:
- OP encoding constants OP_LOAD, OP_INC, OP_DEC, OP_CLR;
- the 2-bit op typedef.
REQ-031 Sub-module reg_bank_cell SHALL implement one WIDTH-bit register with next-state op logic and a wrap output; reg_bank_n SHALL instantiate DEPTH cells in a generate loop.
REQ-032 The WRAP flop and the read multiplexers SHALL reside in reg_bank_n.

Verification
REQ-033 Reset: RST_N=0 mid-cycle after loads -> QA=QB=0x00 and WRAP=0 immediately, without waiting for a clock edge.
REQ-034 Load/read: EN=0, OP=00, WA=2, D=0xA5; then RA=2, RB=1 -> QA=0xA5, QB=0x00.
REQ-035 Increment wrap: load reg1=0xFF, then OP=01 on WA=1 -> reg1=0x00 and WRAP=1 for exactly one cycle.
REQ-036 Decrement wrap: clear reg3, then OP=10 on WA=3 -> reg3=0xFF and WRAP=1; next EN=1 cycle -> WRAP=0.
REQ-037 Hold and range:
- EN=1 with OP=11 -> all registers unchanged.
- With DEPTH=3, EN=0 to WA=3 -> no change, WRAP=0, read RA=3 returns 0x00.
REQ-038 Bypass: with REG_BANK_BYPASS_EN defined, EN=0, OP=00, WA=RA=0, D=0x3C -> QA=0x3C before the edge; undefined -> QA holds the old value until the edge.
